// File: rtl/basys3_pkg.sv
// ---------------------------------------------------------------------------
// basys3_pkg
// Board-level constants shared by the Basys3 front-end stages.
//   CLK_HZ            : board oscillator frequency
//   SWT_WIDTH         : number of slide switches fed into the AOI path
//   DB_MS             : debounce settling time in milliseconds
//   DB_CYCLES_DEFAULT : settling time expressed in CLK cycles
//   SEG_DIGIT_0/1     : active-low 7-segment patterns shared with the display
//   cnt_width()       : counter width able to hold 0 .. cycles-1 (at least 1)
// ---------------------------------------------------------------------------
package basys3_pkg;

  localparam int CLK_HZ            = 100000000;
  localparam int SWT_WIDTH         = 4;
  localparam int DB_MS             = 10;
  localparam int DB_CYCLES_DEFAULT = CLK_HZ / 1000 * DB_MS;

  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;

  // A one-cycle debounce still needs a 1-bit counter so the port widths
  // never collapse to zero.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Single switch bit: SYNC_STAGES-deep synchroniser, stability counter and
// registered rise/fall strobes.
//   clk   : board clock
//   rst_n : synchronous, active-low reset
//   din   : raw asynchronous switch pin
//   dout  : debounced level
//   rise  : one-cycle pulse in the cycle dout goes 0 -> 1
//   fall  : one-cycle pulse in the cycle dout goes 1 -> 0
// ---------------------------------------------------------------------------
module debounce_bit
  import basys3_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync;

  // Oldest stage of the shift chain is the only value the filter looks at.
  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: pure flops, nothing in between, so metastability
  // has the full chain to resolve before any decision is made on it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Stability filter: the counter runs only while the synchronised input
  // disagrees with the published level. Any agreeing cycle clears it, so a
  // bounce has to stay away for DB_CYCLES straight cycles to get through.
  // The counter is cleared on the qualifying cycle instead of incrementing,
  // which keeps it within 0 .. DB_CYCLES-1 and it can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt  <= '0;
        dout <= sync;
        rise <= sync;
        fall <= ~sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/swt_debounce.sv
// ---------------------------------------------------------------------------
// swt_debounce
// Conditions the Basys3 slide switches before the AOI / 7-segment path.
// Each bit is synchronised and debounced independently; SWT_OUT[0..3] feed
// AOI inputs a..d.
//   CLK      : 100 MHz board clock
//   RST_N    : synchronous, active-low reset
//   SWT_IN   : raw asynchronous switch pins
//   SWT_OUT  : debounced switch levels
//   SWT_RISE : per-bit one-cycle pulse when SWT_OUT goes 0 -> 1
//   SWT_FALL : per-bit one-cycle pulse when SWT_OUT goes 1 -> 0
//   SWT_CHG  : high in any cycle where some bit of SWT_OUT changed
// ---------------------------------------------------------------------------
module swt_debounce
  import basys3_pkg::*;
#(
  parameter int WIDTH       = SWT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SWT_IN,
  output logic [WIDTH-1:0] SWT_OUT,
  output logic [WIDTH-1:0] SWT_RISE,
  output logic [WIDTH-1:0] SWT_FALL,
  output logic             SWT_CHG
);

  // One fully independent filter per switch.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_bit (
      .clk  (CLK),
      .rst_n(RST_N),
      .din  (SWT_IN[i]),
      .dout (SWT_OUT[i]),
      .rise (SWT_RISE[i]),
      .fall (SWT_FALL[i])
    );
  end

  // The strobes are already registered, so the reduction is glitch-free and
  // lands in the same cycle as the SWT_OUT change; several bits qualifying
  // together still give a single pulse.
  assign SWT_CHG = |(SWT_RISE | SWT_FALL);

endmodule

// File: tb/tb_swt_debounce.sv
// ---------------------------------------------------------------------------
// tb_swt_debounce
// Self-checking bench for swt_debounce with DB_CYCLES=8, SYNC_STAGES=2.
// The reference model states the debounce rule directly: a bit flips when
// the last DB_CYCLES synchronised samples all disagree with its current
// level, where the synchronised sample is SWT_IN from SYNC_STAGES edges back.
// ---------------------------------------------------------------------------
module tb_swt_debounce;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DB   = 8;

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] SWT_IN;
  logic [W-1:0] SWT_OUT;
  logic [W-1:0] SWT_RISE;
  logic [W-1:0] SWT_FALL;
  logic         SWT_CHG;

  int checks = 0;
  int errors = 0;

  swt_debounce #(
    .WIDTH      (W),
    .SYNC_STAGES(SYNC),
    .DB_CYCLES  (DB)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SWT_IN  (SWT_IN),
    .SWT_OUT (SWT_OUT),
    .SWT_RISE(SWT_RISE),
    .SWT_FALL(SWT_FALL),
    .SWT_CHG (SWT_CHG)
  );

  // 100 MHz clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state: raw samples still travelling through the
  // synchroniser, and the window of recent synchronised samples.
  logic [W-1:0] pipeQ[$];
  logic [W-1:0] winQ[$];
  logic [W-1:0] mOut;
  logic [W-1:0] mRise;
  logic [W-1:0] mFall;

  // Advance the model by one clock edge with the inputs that edge sampled.
  task automatic modelEdge(input logic rst, input logic [W-1:0] sw);
    logic [W-1:0] used;
    logic [W-1:0] newOut;
    bit           allDiffer;
    if (!rst) begin
      pipeQ.delete();
      for (int k = 0; k < SYNC; k++) pipeQ.push_back('0);
      winQ.delete();
      mOut  = '0;
      mRise = '0;
      mFall = '0;
    end else begin
      used = pipeQ.pop_front();
      pipeQ.push_back(sw);
      winQ.push_back(used);
      if (winQ.size() > DB) void'(winQ.pop_front());
      newOut = mOut;
      for (int b = 0; b < W; b++) begin
        allDiffer = (winQ.size() == DB);
        for (int k = 0; k < winQ.size(); k++)
          if (winQ[k][b] == mOut[b]) allDiffer = 1'b0;
        if (allDiffer) newOut[b] = ~mOut[b];
      end
      mRise = newOut & ~mOut;
      mFall = ~newOut & mOut;
      mOut  = newOut;
    end
  endtask

  task automatic checkBits(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, plus the rise/fall exclusivity.
  task automatic checkOutput();
    checkBits("model_out", SWT_OUT, mOut);
    checkBits("model_rise", SWT_RISE, mRise);
    checkBits("model_fall", SWT_FALL, mFall);
    checkBit("model_chg", SWT_CHG, |(mRise | mFall));
    checkBits("rise_and_fall", SWT_RISE & SWT_FALL, '0);
  endtask

  // Drive inputs, take one edge, update the model, sample 1 ns later.
  task automatic applyStimulus(input logic rst, input logic [W-1:0] sw);
    RST_N  = rst;
    SWT_IN = sw;
    @(posedge CLK);
    modelEdge(rst, sw);
    #1;
    checkOutput();
  endtask

  initial begin
    int rem[W];
    int strobes;
    logic [W-1:0] base;
    logic [W-1:0] v;

    RST_N  = 1'b0;
    SWT_IN = '0;
    mOut   = '0;
    mRise  = '0;
    mFall  = '0;

    // Test 1: reset, then bit 0 switched on during reset and held.
    applyStimulus(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0001);
    checkBits("t1_reset_out", SWT_OUT, 4'b0000);
    checkBit("t1_reset_chg", SWT_CHG, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 4'b0001);
      checkBits("t1_hold_out", SWT_OUT, 4'b0000);
    end
    applyStimulus(1'b1, 4'b0001);
    checkBits("t1_edge10_out", SWT_OUT, 4'b0001);
    checkBits("t1_edge10_rise", SWT_RISE, 4'b0001);
    checkBit("t1_edge10_chg", SWT_CHG, 1'b1);
    applyStimulus(1'b1, 4'b0001);
    checkBits("t1_edge11_rise", SWT_RISE, 4'b0000);
    checkBit("t1_edge11_chg", SWT_CHG, 1'b0);

    // Test 2: bit 0 bounces with 3-cycle runs, then settles low.
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, (((c / 3) % 2) != 0) ? 4'b0001 : 4'b0000);
      checkBits("t2_bounce_out", SWT_OUT, 4'b0001);
      checkBit("t2_bounce_chg", SWT_CHG, 1'b0);
    end
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 4'b0000);
      checkBits("t2_hold_out", SWT_OUT, 4'b0001);
    end
    applyStimulus(1'b1, 4'b0000);
    checkBits("t2_edge10_out", SWT_OUT, 4'b0000);
    checkBits("t2_edge10_fall", SWT_FALL, 4'b0001);

    // Test 3: all four switches on at once.
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 4'b1111);
      checkBits("t3_hold_out", SWT_OUT, 4'b0000);
    end
    applyStimulus(1'b1, 4'b1111);
    checkBits("t3_edge10_out", SWT_OUT, 4'b1111);
    checkBits("t3_edge10_rise", SWT_RISE, 4'b1111);
    checkBit("t3_edge10_chg", SWT_CHG, 1'b1);
    applyStimulus(1'b1, 4'b1111);
    checkBit("t3_edge11_chg", SWT_CHG, 1'b0);

    // Test 4: reset in the middle of a count.
    for (int e = 1; e <= 5; e++) applyStimulus(1'b1, 4'b0100);
    checkBits("t4_precount_out", SWT_OUT, 4'b1111);
    applyStimulus(1'b0, 4'b0100);
    checkBits("t4_reset_out", SWT_OUT, 4'b0000);
    checkBits("t4_reset_rise", SWT_RISE, 4'b0000);
    checkBits("t4_reset_fall", SWT_FALL, 4'b0000);
    checkBit("t4_reset_chg", SWT_CHG, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 4'b0100);
      checkBits("t4_hold_out", SWT_OUT, 4'b0000);
    end
    applyStimulus(1'b1, 4'b0100);
    checkBits("t4_edge10_out", SWT_OUT, 4'b0100);
    checkBits("t4_edge10_rise", SWT_RISE, 4'b0100);

    // Test 5: AOI-style input patterns a=b=1, then a=c=1.
    for (int e = 1; e <= 10; e++) applyStimulus(1'b1, 4'b0011);
    checkBits("t5a_out", SWT_OUT, 4'b0011);
    checkBits("t5a_rise", SWT_RISE, 4'b0011);
    checkBits("t5a_fall", SWT_FALL, 4'b0100);
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 4'b0101);
      checkBits("t5b_hold_out", SWT_OUT, 4'b0011);
    end
    applyStimulus(1'b1, 4'b0101);
    checkBits("t5b_out", SWT_OUT, 4'b0101);
    checkBits("t5b_rise", SWT_RISE, 4'b0100);
    checkBits("t5b_fall", SWT_FALL, 4'b0010);

    // Test 6: random bursts of 1..7 deviating cycles on every bit, each
    // burst followed by at least one cycle back at the settled level.
    base    = 4'b0101;
    strobes = 0;
    for (int b = 0; b < W; b++) rem[b] = 0;
    for (int c = 0; c < 10000; c++) begin
      v = base;
      for (int b = 0; b < W; b++) begin
        if (rem[b] > 0) begin
          v[b] = ~base[b];
          rem[b]--;
        end else if ($urandom_range(1, 0) == 1) begin
          rem[b] = int'($urandom_range(7, 1));
        end
      end
      applyStimulus(1'b1, v);
      checkBits("t6_out_stable", SWT_OUT, base);
      if ((SWT_RISE | SWT_FALL) != '0) strobes++;
    end
    for (int e = 1; e <= 12; e++) applyStimulus(1'b1, base);
    checkBits("t6_final_out", SWT_OUT, base);
    checks++;
    assert (strobes == 0)
    else begin
      errors++;
      $error("[TB] FAIL t6_strobe_count observed=%0d expected=0", strobes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swt_debounce.md
Name: swt_debounce

Overview:
Upstream conditioning stage between the Basys3 slide switches and the AOI logic/7-segment path.
- Synchronises each raw switch to CLK.
- Filters contact bounce with a per-bit stability counter.
- Presents clean levels on SWT_OUT, plus one-cycle rise, fall and change strobes for downstream logic.
- SWT_OUT connects directly to the AOI inputs a, b, c, d (bit 0 to a, through bit 3 to d).

Parameters:
- WIDTH, 4: number of switch bits filtered, each independently.
- SYNC_STAGES, 2: flip-flop synchroniser depth per bit; legal range is 2 or more.
- DB_CYCLES, 1000000: consecutive stable cycles required before SWT_OUT follows the input. At 100 MHz this is 10 ms. Legal range is 1 or more.

Ports:
- CLK, input, 1: 100 MHz board clock.
- RST_N, input, 1: synchronous, active-low reset.
- SWT_IN, input, WIDTH: raw, asynchronous switch pins.
- SWT_OUT, output, WIDTH: debounced switch levels.
- SWT_RISE, output, WIDTH: one-cycle pulse per bit when SWT_OUT goes from 0 to 1.
- SWT_FALL, output, WIDTH: one-cycle pulse per bit when SWT_OUT goes from 1 to 0.
- SWT_CHG, output, 1: OR-reduction of (SWT_RISE | SWT_FALL).

Behaviour:
- Reset (RST_N=0 sampled at a CLK edge):
  - All synchroniser flops, counters, SWT_OUT, SWT_RISE, SWT_FALL and SWT_CHG go to 0.
  - Reset overrides all other activity, including a count in progress.
  - The count restarts from 0 after release.
- Synchroniser: sync[i] is the SYNC_STAGES-deep registered copy of SWT_IN[i]. No logic is applied before the last stage.
- Per-bit counter:
  - Width is clog2(DB_CYCLES), minimum 1 bit.
  - The counter saturates by construction and never wraps.
- Each cycle, per bit i:
  - If sync[i] == SWT_OUT[i]: counter clears to 0.
  - If sync[i] != SWT_OUT[i] and counter < DB_CYCLES-1: counter increments.
  - If sync[i] != SWT_OUT[i] and counter == DB_CYCLES-1:
    - SWT_OUT[i] takes the value of sync[i].
    - Counter clears.
    - SWT_RISE[i] or SWT_FALL[i] is set for exactly the next cycle.
- Latency:
  - From the first CLK edge that samples a new stable SWT_IN[i] to SWT_OUT[i] changing is SYNC_STAGES + DB_CYCLES edges.
  - Strobes are registered and asserted in the same cycle SWT_OUT changes.
- Glitch rejection:
  - Any single cycle with sync[i] == SWT_OUT[i] restarts the count.
  - A bounce shorter than DB_CYCLES cycles never reaches SWT_OUT.
- DB_CYCLES=1: SWT_OUT[i] follows sync[i] with one cycle of delay and a strobe on every change.
- Bit independence:
  - Bits are fully independent.
  - Simultaneous qualification of several bits sets several strobe bits in the same cycle, with SWT_CHG=1 once.
- Strobes:
  - SWT_RISE and SWT_FALL are never both 1 for the same bit.
  - They are 0 in every cycle in which SWT_OUT does not change.
- Power-up with a switch already ON: after reset release the bit qualifies normally, and SWT_OUT rises with a SWT_RISE pulse after SYNC_STAGES + DB_CYCLES edges.
- Input held at the opposite level: after one change, the counter stays cleared and no further strobes occur.
- Reset mid-count: the count is discarded and SWT_OUT returns to 0.

Decomposition:
- Shared package basys3_pkg holds:
  - CLK_HZ = 100000000
  - SWT_WIDTH = 4
  - DB_MS = 10
  - derived DB_CYCLES_DEFAULT = CLK_HZ/1000*DB_MS
  - the 7-segment digit constants SEG_DIGIT_0 = 7'b1000000 and SEG_DIGIT_1 = 7'b1111001, so they are shared with the display stage
- One sub-module, debounce_bit:
  - Single-bit synchroniser, counter and edge logic, parameterised by SYNC_STAGES and DB_CYCLES.
  - Instantiated WIDTH times by a generate loop.
  - The top level adds only the SWT_CHG reduction.

Test Plan (DB_CYCLES=8, SYNC_STAGES=2 for simulation):
1. Reset, then SWT_IN=4'b0001 held stable:
   - SWT_OUT stays 4'b0000 for 9 edges after reset release.
   - On edge 10, SWT_OUT=4'b0001, with SWT_RISE=4'b0001 and SWT_CHG=1 for exactly 1 cycle.
2. SWT_OUT=4'b0001, then SWT_IN[0] bounces 0/1 with a 3-cycle period for 40 cycles, then stays 0:
   - No change during the bounce.
   - SWT_OUT=4'b0000 and SWT_FALL=4'b0001 exactly 10 edges after the last transition.
3. SWT_IN goes from 4'b0000 to 4'b1111 in one cycle:
   - All four bits change on the same edge.
   - SWT_RISE=4'b1111, and SWT_CHG is a single 1-cycle pulse.
4. SWT_IN=4'b0100 held for 5 cycles, then RST_N=0 for 1 cycle, then held:
   - Outputs are 0 during reset.
   - SWT_OUT=4'b0100 exactly 10 edges after reset release, not earlier.
5. Integration with the AOI stage: SWT_IN=4'b0011 stable:
   - After the debounce delay, SEG shows '0' (7'b1000000).
   - Then SWT_IN=4'b0101: SEG shows '1' (7'b1111001) 10 edges after the change.
6. Random bounce bursts shorter than 8 cycles on all bits for 10k cycles, with the scoreboard run against a behavioural model:
   - Zero strobes and no SWT_OUT changes.
   - Assertion that SWT_RISE & SWT_FALL == 0 in every cycle.
